// File: rtl/pool2_stream_out.sv
// ----------------------------------------------------------------------------
// pool2_stream_out
//
// Takes a snapshot of one complete ROWS x COLS pooled feature map on a
// valid/ready capture handshake. It then streams the map out one word per beat
// in raster order (row-major, column fastest) over a backpressurable
// valid/ready interface.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   in_valid     map_in holds a complete pooled map
//   in_ready     block can capture a map this cycle (IDLE and out of reset)
//   map_in       pooled map, [0:ROWS-1][0:COLS-1], BW bits per element
//   out_valid    out_data/out_row/out_col/out_last are valid
//   out_ready    sink accepts the current beat
//   out_data     snapshot element at (out_row, out_col)
//   out_row      row index of the current beat
//   out_col      column index of the current beat
//   out_last     current beat is element (ROWS-1, COLS-1)
//   frames_sent  count of fully streamed frames, wraps at 2^16
// ----------------------------------------------------------------------------
module pool2_stream_out #(
   parameter int BW   = 8,
   parameter int ROWS = 13,
   parameter int COLS = 13,
   // A 1-entry dimension still gets a 1-bit index so the ports never vanish.
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] map_in [0:ROWS-1][0:COLS-1],
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_data,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          out_last,
   output logic [15:0]   frames_sent
);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [RW-1:0]   row_reg;
   logic [CW-1:0]   col_reg;
   logic [15:0]     frames_reg;
   logic [BW-1:0]   snap_reg [0:ROWS-1][0:COLS-1];

   logic            capture;
   logic            beat;
   logic            last_beat;
   logic            at_last_col;
   logic            at_last_row;

   // in_ready is gated by rst directly so it is low for the whole reset
   // assertion, not only after the state register has been cleared.
   assign in_ready    = rst & (state_reg == IDLE);
   assign out_valid   = (state_reg == STREAM);
   assign capture     = in_valid & in_ready;
   assign beat        = out_valid & out_ready;
   assign at_last_col = (col_reg == CW'(COLS - 1));
   assign at_last_row = (row_reg == RW'(ROWS - 1));
   assign out_last    = at_last_row & at_last_col & out_valid;
   assign last_beat   = beat & out_last;

   assign out_row     = row_reg;
   assign out_col     = col_reg;
   assign out_data    = snap_reg[row_reg][col_reg];
   assign frames_sent = frames_reg;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state. STREAM ignores in_valid entirely; the only way out
   // is the accepted last beat.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (capture) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (last_beat) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Raster position counters and completed-frame counter.
   // Counters only move on a beat, so every output holds during a stall.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_reg    <= '0;
         col_reg    <= '0;
         frames_reg <= '0;
      end else if (capture) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (beat) begin
         if (last_beat) begin
            row_reg    <= '0;
            col_reg    <= '0;
            frames_reg <= frames_reg + 16'd1;
         end else if (at_last_col) begin
            col_reg <= '0;
            row_reg <= row_reg + RW'(1);
         end else begin
            col_reg <= col_reg + CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Snapshot. The whole map is copied in a single edge, so it has to be
   // a register array rather than a RAM. Once captured, it is decoupled
   // from map_in.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               snap_reg[r][c] <= '0;
            end
         end
      end else if (capture) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               snap_reg[r][c] <= map_in[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_pool2_stream_out.sv
module tb_pool2_stream_out;

   localparam int R = 13;
   localparam int C = 13;
   localparam int N = R * C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  map_in [0:R-1][0:C-1];
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [3:0]  out_row;
   logic [3:0]  out_col;
   logic        out_last;
   logic [15:0] frames_sent;

   // 1x1 build
   logic        in_valid1 = 1'b0;
   logic        in_ready1;
   logic [7:0]  map1 [0:0][0:0];
   logic        out_valid1;
   logic        out_ready1 = 1'b0;
   logic [7:0]  out_data1;
   logic [0:0]  out_row1;
   logic [0:0]  out_col1;
   logic        out_last1;
   logic [15:0] frames_sent1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_frames = 0;

   // Reference model: the map the DUT should have captured, plus beats seen.
   logic [7:0] ref_map  [0:R-1][0:C-1];
   logic [7:0] ref_map2 [0:R-1][0:C-1];
   int b_data[$];
   int b_row[$];
   int b_col[$];
   int b_last[$];
   int b_cyc[$];
   int stall_changes;
   int ready_in_stream;
   bit timed_out;

   pool2_stream_out #(.BW(8), .ROWS(R), .COLS(C)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .map_in(map_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_col(out_col),
      .out_last(out_last), .frames_sent(frames_sent)
   );

   pool2_stream_out #(.BW(8), .ROWS(1), .COLS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .map_in(map1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .out_row(out_row1), .out_col(out_col1),
      .out_last(out_last1), .frames_sent(frames_sent1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // mode 0: r*13+c, 1: random, 2: all 8'hFF
   task automatic set_map(input int mode);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            case (mode)
               0: map_in[r][c] = 8'(r * C + c);
               1: map_in[r][c] = 8'($urandom_range(0, 255));
               default: map_in[r][c] = 8'hFF;
            endcase
   endtask

   task automatic snap_ref();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            ref_map[r][c] = map_in[r][c];
   endtask

   // Records accepted beats until the last beat is taken. Returns one cycle
   // after the last-beat edge, sampled #1 after that edge.
   // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready
   task automatic collect(input int mode, input int max_cycles);
      int k;
      bit pstall;
      bit done;
      logic [7:0] pd;
      logic [3:0] pr, pc;
      logic pl;
      k = 0; pstall = 0; pd = '0; pr = '0; pc = '0; pl = 1'b0;
      b_data.delete(); b_row.delete(); b_col.delete(); b_last.delete(); b_cyc.delete();
      stall_changes = 0; ready_in_stream = 0; timed_out = 0;
      forever begin
         if (pstall && (out_valid !== 1'b1 || out_data !== pd || out_row !== pr ||
                        out_col !== pc || out_last !== pl))
            stall_changes++;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
         if (out_valid && in_ready) ready_in_stream++;
         if (out_valid && out_ready) begin
            b_data.push_back(int'(out_data));
            b_row.push_back(int'(out_row));
            b_col.push_back(int'(out_col));
            b_last.push_back(int'(out_last));
            b_cyc.push_back(cyc);
         end
         pstall = out_valid && !out_ready;
         pd = out_data; pr = out_row; pc = out_col; pl = out_last;
         done = out_valid && out_ready && out_last;
         @(posedge clk); #1;
         if (done) break;
         if (k >= max_cycles) begin
            timed_out = 1;
            break;
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 ||
          out_row !== 4'd0 || out_col !== 4'd0 || frames_sent !== 16'd0 || out_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b last=%b row=%0d col=%0d frames=%0d data=%0d, want all 0",
                  out_valid, in_ready, out_last, out_row, out_col, frames_sent, out_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
      end
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      set_map(0);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_row !== 4'd0 || out_col !== 4'd0) begin
         errors++;
         $display("FAIL basic_latency: valid=%b row=%0d col=%0d want 1,0,0", out_valid, out_row, out_col);
      end
      collect(0, 400);
      exp_frames++;
      checks++;
      if (timed_out || b_data.size() != N) begin
         errors++;
         $display("FAIL basic_count: beats=%0d timeout=%0d want %0d", b_data.size(), timed_out, N);
      end
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map[i / C][i % C]) || b_row[i] != i / C ||
             b_col[i] != i % C || b_last[i] != int'(i == N - 1)) begin
            errors++;
            $display("FAIL basic_beat[%0d]: data=%0d row=%0d col=%0d last=%0d want %0d,%0d,%0d,%0d",
                     i, b_data[i], b_row[i], b_col[i], b_last[i],
                     ref_map[i / C][i % C], i / C, i % C, int'(i == N - 1));
         end
      end
      checks++;
      if (out_valid !== 1'b0 || frames_sent !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL basic_end: valid=%b frames=%0d want 0,%0d", out_valid, frames_sent, exp_frames);
      end
      $display("test_basic frame: %0d beats, frames_sent=%0d", b_data.size(), frames_sent);
   endtask

   task automatic test_stall();
      set_map(0);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(1, 1000);
      exp_frames++;
      checks++;
      if (timed_out || b_data.size() != N || stall_changes != 0) begin
         errors++;
         $display("FAIL stall_count: beats=%0d timeout=%0d stall_changes=%0d want %0d,0,0",
                  b_data.size(), timed_out, stall_changes, N);
      end
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map[i / C][i % C]) || b_row[i] != i / C ||
             b_col[i] != i % C || b_last[i] != int'(i == N - 1)) begin
            errors++;
            $display("FAIL stall_beat[%0d]: data=%0d row=%0d col=%0d last=%0d want %0d,%0d,%0d,%0d",
                     i, b_data[i], b_row[i], b_col[i], b_last[i],
                     ref_map[i / C][i % C], i / C, i % C, int'(i == N - 1));
         end
      end
      checks++;
      if (frames_sent !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL stall_frames: frames=%0d want %0d", frames_sent, exp_frames);
      end
      $display("test_stall frame: %0d beats, stall_changes=%0d", b_data.size(), stall_changes);
   endtask

   task automatic test_busy_ignore();
      set_map(1);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      set_map(2);                   // in_valid stays high during STREAM
      collect(2, 1000);
      exp_frames++;
      checks++;
      if (timed_out || b_data.size() != N || ready_in_stream != 0) begin
         errors++;
         $display("FAIL busy_count: beats=%0d timeout=%0d ready_in_stream=%0d want %0d,0,0",
                  b_data.size(), timed_out, ready_in_stream, N);
      end
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map[i / C][i % C])) begin
            errors++;
            $display("FAIL busy_data[%0d]: got %0d want %0d", i, b_data[i], ref_map[i / C][i % C]);
         end
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle_gap: ready=%b valid=%b want 1,0", in_ready, out_valid);
      end
      snap_ref();
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
         errors++;
         $display("FAIL busy_recapture: valid=%b data=%0h want 1,ff", out_valid, out_data);
      end
      collect(0, 400);
      exp_frames++;
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != 255) begin
            errors++;
            $display("FAIL busy_second[%0d]: got %0d want 255", i, b_data[i]);
         end
      end
      checks++;
      if (b_data.size() != N || frames_sent !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL busy_end: beats=%0d frames=%0d want %0d,%0d", b_data.size(), frames_sent, N, exp_frames);
      end
      $display("test_busy_ignore: two frames, frames_sent=%0d", frames_sent);
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      t1 = 0; t2 = 0;
      set_map(1);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      set_map(1);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            ref_map2[r][c] = map_in[r][c];
      collect(0, 400);
      exp_frames++;
      if (b_cyc.size() > 0) t1 = b_cyc[0];
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map[i / C][i % C])) begin
            errors++;
            $display("FAIL b2b_first[%0d]: got %0d want %0d", i, b_data[i], ref_map[i / C][i % C]);
         end
      end
      @(posedge clk); #1;           // capture of the second map in the IDLE gap
      in_valid = 1'b0;
      collect(0, 400);
      exp_frames++;
      if (b_cyc.size() > 0) t2 = b_cyc[0];
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map2[i / C][i % C])) begin
            errors++;
            $display("FAIL b2b_second[%0d]: got %0d want %0d", i, b_data[i], ref_map2[i / C][i % C]);
         end
      end
      checks++;
      if (t2 - t1 != N + 1 || b_data.size() != N) begin
         errors++;
         $display("FAIL b2b_spacing: spacing=%0d beats=%0d want %0d,%0d", t2 - t1, b_data.size(), N + 1, N);
      end
      checks++;
      if (frames_sent !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL b2b_frames: frames=%0d want %0d", frames_sent, exp_frames);
      end
      $display("test_back_to_back: spacing=%0d frames_sent=%0d", t2 - t1, frames_sent);
   endtask

   task automatic test_random_backpressure();
      for (int f = 0; f < 3; f++) begin
         set_map(1);
         snap_ref();
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         set_map(1);                // scramble input after capture
         collect(2, 1500);
         exp_frames++;
         checks++;
         if (timed_out || b_data.size() != N || stall_changes != 0) begin
            errors++;
            $display("FAIL rand_count[%0d]: beats=%0d timeout=%0d stall_changes=%0d", f,
                     b_data.size(), timed_out, stall_changes);
         end
         for (int i = 0; i < b_data.size() && i < N; i++) begin
            checks++;
            if (b_data[i] != int'(ref_map[i / C][i % C]) || b_row[i] != i / C ||
                b_col[i] != i % C || b_last[i] != int'(i == N - 1)) begin
               errors++;
               $display("FAIL rand_beat[%0d][%0d]: data=%0d row=%0d col=%0d last=%0d want %0d,%0d,%0d,%0d",
                        f, i, b_data[i], b_row[i], b_col[i], b_last[i],
                        ref_map[i / C][i % C], i / C, i % C, int'(i == N - 1));
            end
         end
         checks++;
         if (frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL rand_frames[%0d]: frames=%0d want %0d", f, frames_sent, exp_frames);
         end
         $display("test_random_backpressure frame %0d: %0d beats", f, b_data.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      bit found;
      found = 0;
      set_map(1);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 300; k++) begin
         out_ready = 1'b1;
         if (out_valid && out_row == 4'd3 && out_col == 4'd11) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!found || out_data !== ref_map[3][11]) begin
         errors++;
         $display("FAIL midrst_reach: found=%0d data=%0d want 1,%0d", found, out_data, ref_map[3][11]);
      end
      rst = 1'b0;
      #1;
      exp_frames = 0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 || frames_sent !== 16'd0) begin
         errors++;
         $display("FAIL midrst_async: valid=%b ready=%b last=%b frames=%0d want 0,0,0,0",
                  out_valid, in_ready, out_last, frames_sent);
      end
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_row !== 4'd0 || out_col !== 4'd0 || frames_sent !== 16'd0) begin
         errors++;
         $display("FAIL midrst_release: ready=%b row=%0d col=%0d frames=%0d want 1,0,0,0",
                  in_ready, out_row, out_col, frames_sent);
      end
      @(posedge clk); #1;
      set_map(1);
      snap_ref();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(0, 400);
      exp_frames++;
      for (int i = 0; i < b_data.size() && i < N; i++) begin
         checks++;
         if (b_data[i] != int'(ref_map[i / C][i % C]) || b_row[i] != i / C || b_col[i] != i % C) begin
            errors++;
            $display("FAIL midrst_new[%0d]: data=%0d row=%0d col=%0d want %0d,%0d,%0d",
                     i, b_data[i], b_row[i], b_col[i], ref_map[i / C][i % C], i / C, i % C);
         end
      end
      checks++;
      if (b_data.size() != N || frames_sent !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL midrst_end: beats=%0d frames=%0d want %0d,%0d", b_data.size(), frames_sent, N, exp_frames);
      end
      $display("test_reset_mid_frame: restart frame %0d beats, frames_sent=%0d", b_data.size(), frames_sent);
   endtask

   task automatic test_single();
      logic [7:0] v;
      int exp1;
      exp1 = 0;
      for (int t = 0; t < 3; t++) begin
         v = (t == 0) ? 8'h01 : 8'($urandom_range(0, 255));
         map1[0][0] = v;
         in_valid1 = 1'b1;
         @(posedge clk); #1;
         in_valid1 = 1'b0;
         map1[0][0] = ~v;
         out_ready1 = 1'b1;
         checks++;
         if (out_valid1 !== 1'b1 || out_data1 !== v || out_last1 !== 1'b1 ||
             out_row1 !== 1'b0 || out_col1 !== 1'b0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL single_beat[%0d]: valid=%b data=%0h last=%b row=%0d col=%0d ready=%b want 1,%0h,1,0,0,0",
                     t, out_valid1, out_data1, out_last1, out_row1, out_col1, in_ready1, v);
         end
         @(posedge clk); #1;
         out_ready1 = 1'b0;
         exp1++;
         checks++;
         if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || frames_sent1 !== 16'(exp1)) begin
            errors++;
            $display("FAIL single_idle[%0d]: valid=%b ready=%b frames=%0d want 0,1,%0d",
                     t, out_valid1, in_ready1, frames_sent1, exp1);
         end
         $display("test_single %0d: data=%0h frames_sent=%0d", t, out_data1, frames_sent1);
      end
   endtask

   initial begin
      set_map(0);
      map1[0][0] = 8'h00;
      test_reset();
      test_basic();
      test_stall();
      test_busy_ignore();
      test_back_to_back();
      test_random_backpressure();
      test_reset_mid_frame();
      test_single();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
